wdt_window: RTL and testbench
=============================

Name: wdt_window

Overview:
Parametrised windowed watchdog timer, the successor to the team's single-stage WDT. It is a down-counter with a prescaled tick and a programmable early-warning interrupt stage (rst_int). A timeout produces a fixed-length system-reset pulse (rst_sys), and a sticky reset-cause register records why it fired. With the optional window feature enabled, a kick that arrives too early is also a violation. The block sits beside the system reset controller: rst_int goes to the interrupt controller and rst_sys goes to the reset tree.

Parameters:
- CNT_W, 24, width of the counter and of all load values.
- PRESCALE, 1, clk cycles per counter tick (≥1; a value of 1 means one tick every cycle).
- RST_PULSE, 4, number of clk cycles rst_sys is held high (≥1).

Ports:
- clk, in, 1, system clock; all state is updated on its rising edge.
- rst, in, 1, asynchronous reset, active-high.
- en, in, 1, watchdog enable (level).
- kick, in, 1, service strobe; sampled as a level once per clk.
- ld_en, in, 1, load strobe for the three configuration values below.
- ld_cnt, in, CNT_W, timeout reload value.
- ld_warn, in, CNT_W, warning threshold; 0 disables the warning stage.
- ld_win, in, CNT_W, window-open threshold; ignored unless WDT_WINDOW_EN is defined.
- rst_sys, out, 1, system-reset pulse.
- rst_int, out, 1, early-warning interrupt (level).
- cnt, out, CNT_W, current counter value.
- rst_cause, out, 2, sticky cause: 00 none, 01 timeout, 10 early kick.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset values:
  - Outputs: cnt=0, rst_sys=0, rst_int=0, rst_cause=00.
  - Internal: tmo_r=0, warn_r=0, win_r=0, prescaler=0, state=IDLE.
- Tick: the prescaler counts 0..PRESCALE-1 while in RUN or WARN. Tick is high when prescaler==PRESCALE-1. The prescaler clears on reload, kick, load and entry to RUN.
- State IDLE:
  - cnt holds tmo_r.
  - en=1 → RUN on the next edge, with cnt=tmo_r.
- State RUN:
  - On tick, cnt decrements by 1.
  - If warn_r≠0 and the decremented value ≤ warn_r → WARN, and rst_int=1 on the same edge.
  - If the decremented value is 0 → BITE.
- State WARN:
  - rst_int held at 1; cnt continues to decrement on tick.
  - cnt reaching 0 → BITE.
- Kick in RUN or WARN: cnt=tmo_r, rst_int=0, state → RUN.
- en=0 in RUN or WARN: → IDLE, rst_int=0, cnt=tmo_r.
- State BITE:
  - rst_sys=1, asserted on the same edge that enters BITE, and held for exactly RST_PULSE cycles.
  - rst_cause is set on entry.
  - kick and ld_en are ignored throughout BITE.
  - After the pulse: rst_sys=0, cnt=tmo_r, then → RUN if en=1, else → IDLE.
- Load (ld_en=1, any state except BITE):
  - tmo_r=ld_cnt, or 1 if ld_cnt==0.
  - warn_r=ld_warn; win_r=ld_win.
  - cnt=new tmo_r; rst_int=0; rst_cause=00.
  - RUN or WARN → RUN; IDLE stays IDLE.
- Priority in a single cycle: rst > BITE sequencing > ld_en > en=0 > kick > tick. A kick on the same edge as the decrement to 0 reloads the counter; no bite occurs.
- warn_r ≥ tmo_r: WARN is entered on the first tick after reload.
- Timing example: tmo=8, PRESCALE=1, no kicks. rst_sys rises 8 edges after the edge that entered RUN.
- Widths: all compares are unsigned CNT_W-bit. The counter never wraps below 0.

Optional Feature:
- Macro: WDT_WINDOW_EN.
- When defined:
  - A kick in RUN or WARN while cnt > win_r is an early kick. It causes → BITE on the next edge with rst_cause=10, and no reload.
  - win_r ≥ tmo_r means the window is always open.
- When undefined:
  - ld_win and win_r have no effect; all kicks are legal.
  - rst_cause never takes the value 10.

Decomposition:
- Package wdt_pkg:
  - State encoding IDLE/RUN/WARN/BITE.
  - Cause constants CAUSE_NONE=00, CAUSE_TMO=01, CAUSE_EARLY=10.
- Sub-module wdt_prescaler:
  - Parameter PRESCALE; inputs clk, rst, run, clr; output tick.
  - Width is $clog2(PRESCALE), minimum 1.

Test Plan:
1. Basic timeout: ld_cnt=8, ld_warn=0, en=1, no kick → rst_sys high 8 edges after RUN entry, for 4 cycles; rst_cause=01; cnt reloads to 8.
2. Warning and kick recovery: ld_cnt=8, ld_warn=3, en=1 → rst_int rises when cnt=3. A kick at cnt=2 → rst_int=0 and cnt=8; no rst_sys.
3. Simultaneous events:
   - A kick on the edge where cnt goes 1→0 → cnt=8, no bite.
   - ld_en together with kick, ld_cnt=20 → cnt=20, cause cleared.
4. Prescaler and disable: PRESCALE=4, ld_cnt=5 → bite after 20 cycles. Setting en=0 mid-count → IDLE with cnt=5, and no bite for 100 cycles.
5. Window (WDT_WINDOW_EN): ld_cnt=16, ld_win=6.
   - A kick at cnt=10 → BITE next edge, rst_cause=10.
   - A kick at cnt=5 → reload to 16.
   - Without the macro, the same kick at cnt=10 reloads.
6. Reset mid-BITE: assert rst during the 2nd rst_sys cycle → all outputs 0 immediately, state IDLE. ld_en during BITE is ignored.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared types and constants for the windowed watchdog (wdt_window).
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WARN = 2'd2,
    BITE = 2'd3
  } wdt_state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_TMO   = 2'b01;
  localparam logic [1:0] CAUSE_EARLY = 2'b10;

endpackage

// File: rtl/wdt_prescaler.sv
// Tick generator: one tick every PRESCALE clk cycles while run is high.
module wdt_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  assign tick = run & (pre_q == LAST);

  always_comb begin
    pre_d = pre_q + PW'(1);
    if (!run || clr || tick) pre_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

endmodule

// File: rtl/wdt_window.sv
// Windowed watchdog: prescaled down-counter, warning stage, fixed-length bite pulse.
// Define WDT_WINDOW_EN to treat kicks above the window threshold as violations.
module wdt_window
  import wdt_pkg::*;
#(
  parameter int CNT_W     = 24,
  parameter int PRESCALE  = 1,
  parameter int RST_PULSE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             kick,
  input  logic             ld_en,
  input  logic [CNT_W-1:0] ld_cnt,
  input  logic [CNT_W-1:0] ld_warn,
  input  logic [CNT_W-1:0] ld_win,
  output logic             rst_sys,
  output logic             rst_int,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       rst_cause
);

  localparam int PLW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [PLW-1:0] PLS_LAST = PLW'(RST_PULSE - 1);

  wdt_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] warn_q, warn_d;
  logic [1:0]       cause_q, cause_d;
  logic [PLW-1:0]   pls_q, pls_d;
  logic [CNT_W-1:0] dec;
  logic             early;
  logic             tick;
  logic             pre_clr;

`ifdef WDT_WINDOW_EN
  logic [CNT_W-1:0] win_q, win_d;
  assign early = kick & (cnt_q > win_q);
`else
  logic unused_win;
  assign unused_win = ^ld_win;
  assign early      = 1'b0;
`endif

  // Saturating decrement so the counter never wraps below zero.
  assign dec = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

  wdt_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .run  ((state_q == RUN) || (state_q == WARN)),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    warn_d  = warn_q;
    cause_d = cause_q;
    pls_d   = '0;
    pre_clr = 1'b0;
`ifdef WDT_WINDOW_EN
    win_d   = win_q;
`endif
    if (state_q == BITE) begin
      if (pls_q == PLS_LAST) begin
        cnt_d   = tmo_q;
        state_d = en ? RUN : IDLE;
      end else begin
        pls_d = pls_q + PLW'(1);
      end
    end else if (ld_en) begin
      tmo_d   = (ld_cnt == '0) ? CNT_W'(1) : ld_cnt;
      warn_d  = ld_warn;
`ifdef WDT_WINDOW_EN
      win_d   = ld_win;
`endif
      cnt_d   = tmo_d;
      cause_d = CAUSE_NONE;
      state_d = (state_q == IDLE) ? IDLE : RUN;
      pre_clr = 1'b1;
    end else if (state_q == IDLE) begin
      cnt_d = tmo_q;
      if (en) state_d = RUN;
    end else if (!en) begin
      cnt_d   = tmo_q;
      state_d = IDLE;
    end else if (kick) begin
      if (early) begin
        state_d = BITE;
        cause_d = CAUSE_EARLY;
      end else begin
        cnt_d   = tmo_q;
        state_d = RUN;
        pre_clr = 1'b1;
      end
    end else if (tick) begin
      cnt_d = dec;
      if (dec == '0) begin
        state_d = BITE;
        cause_d = CAUSE_TMO;
      end else if (state_q == RUN && warn_q != '0 && dec <= warn_q) begin
        state_d = WARN;
      end
    end
    if (state_d == RUN && state_q != RUN) pre_clr = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      warn_q  <= '0;
      cause_q <= CAUSE_NONE;
      pls_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      warn_q  <= warn_d;
      cause_q <= cause_d;
      pls_q   <= pls_d;
    end
  end

`ifdef WDT_WINDOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) win_q <= '0;
    else     win_q <= win_d;
  end
`endif

  assign rst_sys   = (state_q == BITE);
  assign rst_int   = (state_q == WARN);
  assign cnt       = cnt_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_wdt_window.sv
// Directed self-checking bench for wdt_window (PRESCALE=1 and PRESCALE=4 instances).
module tb_wdt_window;
  import wdt_pkg::*;

  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0, kick = 1'b0, ld_en = 1'b0;
  logic [CNT_W-1:0] ld_cnt = '0, ld_warn = '0, ld_win = '1;
  logic             rst_sys, rst_int, rst_sys4, rst_int4;
  logic [CNT_W-1:0] cnt, cnt4;
  logic [1:0]       rst_cause, rst_cause4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wdt_window #(.CNT_W(CNT_W), .PRESCALE(1), .RST_PULSE(4)) dut (
    .clk(clk), .rst(rst), .en(en), .kick(kick), .ld_en(ld_en),
    .ld_cnt(ld_cnt), .ld_warn(ld_warn), .ld_win(ld_win),
    .rst_sys(rst_sys), .rst_int(rst_int), .cnt(cnt), .rst_cause(rst_cause)
  );

  wdt_window #(.CNT_W(CNT_W), .PRESCALE(4), .RST_PULSE(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .kick(kick), .ld_en(ld_en),
    .ld_cnt(ld_cnt), .ld_warn(ld_warn), .ld_win(ld_win),
    .rst_sys(rst_sys4), .rst_int(rst_int4), .cnt(cnt4), .rst_cause(rst_cause4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] w,
                         input logic [CNT_W-1:0] win);
    ld_en = 1'b1; ld_cnt = c; ld_warn = w; ld_win = win;
    step(1);
    ld_en = 1'b0;
  endtask

  initial begin
    logic saw_bite;

    // Reset values
    #12;
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_sys", 32'(rst_sys), 32'd0);
    chk("rst_int", 32'(rst_int), 32'd0);
    chk("rst_cause", 32'(rst_cause), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. Basic timeout, ld_en ignored during BITE
    do_load(24'd8, 24'd0, '1);
    chk("t1_idle_cnt", 32'(cnt), 32'd8);
    en = 1'b1;
    step(1);
    chk("t1_run_cnt", 32'(cnt), 32'd8);
    step(7);
    chk("t1_cnt1", 32'(cnt), 32'd1);
    chk("t1_no_bite", 32'(rst_sys), 32'd0);
    step(1);
    chk("t1_bite", 32'(rst_sys), 32'd1);
    chk("t1_cause", 32'(rst_cause), 32'd1);
    ld_en = 1'b1; ld_cnt = 24'd3;
    step(3);
    chk("t1_bite_4th", 32'(rst_sys), 32'd1);
    step(1);
    ld_en = 1'b0;
    chk("t1_bite_end", 32'(rst_sys), 32'd0);
    chk("t1_reload", 32'(cnt), 32'd8);
    chk("t1_cause_sticky", 32'(rst_cause), 32'd1);
    chk("t1_run", 32'(dut.state_q), 32'(RUN));

    // 2. Warning and kick recovery
    do_load(24'd8, 24'd3, '1);
    chk("t2_load_cnt", 32'(cnt), 32'd8);
    chk("t2_cause_clr", 32'(rst_cause), 32'd0);
    step(4);
    chk("t2_cnt4", 32'(cnt), 32'd4);
    chk("t2_no_int", 32'(rst_int), 32'd0);
    step(1);
    chk("t2_cnt3", 32'(cnt), 32'd3);
    chk("t2_int", 32'(rst_int), 32'd1);
    step(1);
    chk("t2_cnt2", 32'(cnt), 32'd2);
    kick = 1'b1;
    step(1);
    kick = 1'b0;
    chk("t2_kick_cnt", 32'(cnt), 32'd8);
    chk("t2_kick_int", 32'(rst_int), 32'd0);
    chk("t2_no_sys", 32'(rst_sys), 32'd0);

    // 3. Kick on the 1->0 edge, then load+kick together
    step(7);
    chk("t3_cnt1", 32'(cnt), 32'd1);
    kick = 1'b1;
    step(1);
    kick = 1'b0;
    chk("t3_kick_cnt", 32'(cnt), 32'd8);
    chk("t3_no_bite", 32'(rst_sys), 32'd0);
    chk("t3_int_clr", 32'(rst_int), 32'd0);
    step(8);
    chk("t3_bite", 32'(rst_sys), 32'd1);
    step(4);
    chk("t3_exit_cnt", 32'(cnt), 32'd8);
    chk("t3_cause_pre", 32'(rst_cause), 32'd1);
    kick = 1'b1;
    do_load(24'd20, 24'd0, '1);
    kick = 1'b0;
    chk("t3_ld_kick_cnt", 32'(cnt), 32'd20);
    chk("t3_ld_kick_cause", 32'(rst_cause), 32'd0);

    // 4. Prescaler (dut4) and disable
    rst = 1'b1; en = 1'b0;
    step(1);
    rst = 1'b0;
    do_load(24'd5, 24'd0, '1);
    en = 1'b1;
    step(1);
    chk("t4_entry_cnt", 32'(cnt4), 32'd5);
    step(19);
    chk("t4_cnt_e19", 32'(cnt4), 32'd1);
    chk("t4_no_bite", 32'(rst_sys4), 32'd0);
    step(1);
    chk("t4_bite20", 32'(rst_sys4), 32'd1);
    chk("t4_cause", 32'(rst_cause4), 32'd1);
    step(4);
    chk("t4_exit", 32'(rst_sys4), 32'd0);
    chk("t4_exit_cnt", 32'(cnt4), 32'd5);
    step(6);
    chk("t4_mid_cnt", 32'(cnt4), 32'd4);
    en = 1'b0;
    step(1);
    chk("t4_dis_cnt", 32'(cnt4), 32'd5);
    chk("t4_dis_state", 32'(dut4.state_q), 32'(IDLE));
    saw_bite = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (rst_sys4) saw_bite = 1'b1;
    end
    chk("t4_quiet100", 32'(saw_bite), 32'd0);
    chk("t4_hold_cnt", 32'(cnt4), 32'd5);

    // 5. Window threshold
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    do_load(24'd16, 24'd0, 24'd6);
    en = 1'b1;
    step(1);
    step(6);
    chk("t5_cnt10", 32'(cnt), 32'd10);
    kick = 1'b1;
    step(1);
    kick = 1'b0;
`ifdef WDT_WINDOW_EN
    chk("t5_early_bite", 32'(rst_sys), 32'd1);
    chk("t5_early_cause", 32'(rst_cause), 32'd2);
    step(4);
    chk("t5_exit", 32'(rst_sys), 32'd0);
`else
    chk("t5_legal_sys", 32'(rst_sys), 32'd0);
    chk("t5_legal_cause", 32'(rst_cause), 32'd0);
`endif
    chk("t5_cnt16", 32'(cnt), 32'd16);
    step(11);
    chk("t5_cnt5", 32'(cnt), 32'd5);
    kick = 1'b1;
    step(1);
    kick = 1'b0;
    chk("t5_open_cnt", 32'(cnt), 32'd16);
    chk("t5_open_sys", 32'(rst_sys), 32'd0);

    // 6. Reset during the second rst_sys cycle
    rst = 1'b1; en = 1'b0;
    step(1);
    rst = 1'b0;
    do_load(24'd8, 24'd0, '1);
    en = 1'b1;
    step(1);
    step(8);
    chk("t6_bite", 32'(rst_sys), 32'd1);
    step(1);
    chk("t6_bite2", 32'(rst_sys), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_sys", 32'(rst_sys), 32'd0);
    chk("t6_rst_cnt", 32'(cnt), 32'd0);
    chk("t6_rst_int", 32'(rst_int), 32'd0);
    chk("t6_rst_cause", 32'(rst_cause), 32'd0);
    chk("t6_rst_state", 32'(dut.state_q), 32'(IDLE));
    en = 1'b0;
    step(1);
    rst = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
